// File: rtl/fifo_rd_packer_if.sv
// Read-side bundle for the FIFO packer: FWFT FIFO read port plus the packed
// valid/ready output stream. master = packer side, slave = FIFO/consumer side.
interface fifo_rd_packer_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned RATIO      = 4
);
   logic                          fifo_empty;
   logic [DATA_WIDTH-1:0]         fifo_data;
   logic                          fifo_read;
   logic                          m_valid;
   logic                          m_ready;
   logic [DATA_WIDTH*RATIO-1:0]   m_data;
   logic [RATIO-1:0]              m_keep;
   logic                          m_last;

   modport master (
      input  fifo_empty,
      input  fifo_data,
      output fifo_read,
      output m_valid,
      input  m_ready,
      output m_data,
      output m_keep,
      output m_last
   );

   modport slave (
      output fifo_empty,
      output fifo_data,
      input  fifo_read,
      input  m_valid,
      output m_ready,
      input  m_data,
      input  m_keep,
      input  m_last
   );
endinterface

// File: rtl/fifo_rd_packer.sv
// Read-domain drain engine: packs RATIO FIFO entries little-endian into one wide
// word on a valid/ready stream; flush closes a partial word with a keep mask.
module fifo_rd_packer #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned RATIO      = 4,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                 clk_read,
   input  logic                 rst_n,
   input  logic                 flush,
   output logic                 flush_done,
   output logic [CNT_WIDTH-1:0] word_count,
   fifo_rd_packer_if.master     bus
);

   localparam int unsigned OutW = DATA_WIDTH * RATIO;
   localparam int unsigned IdxW = $clog2(RATIO);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(RATIO - 1);

   typedef enum logic {StFill, StFlush} state_e;

   state_e               state_q, state_d;
   logic [IdxW-1:0]      idx_q, idx_d;
   logic [OutW-1:0]      asm_q, asm_d;
   logic                 m_valid_q, m_valid_d;
   logic [OutW-1:0]      m_data_q, m_data_d;
   logic [RATIO-1:0]     m_keep_q, m_keep_d;
   logic                 m_last_q, m_last_d;
   logic [CNT_WIDTH-1:0] word_count_q, word_count_d;

   logic                 slot_free;
   logic                 pop;
   logic                 flush_done_c;
   logic [OutW-1:0]      lane_word;
   logic [RATIO-1:0]     keep_partial;

   always_comb begin
      slot_free = !m_valid_q || bus.m_ready;
      // The last lane may only be popped if the output register can take the word.
      pop = rst_n && (state_q == StFill) && !bus.fifo_empty &&
            ((idx_q != LastIdx) || slot_free);

      lane_word = asm_q;
      lane_word[idx_q*DATA_WIDTH +: DATA_WIDTH] = bus.fifo_data;

      for (int unsigned k = 0; k < RATIO; k++) begin
         keep_partial[k] = (k < 32'(idx_q));
      end
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      asm_d        = asm_q;
      m_valid_d    = m_valid_q;
      m_data_d     = m_data_q;
      m_keep_d     = m_keep_q;
      m_last_d     = m_last_q;
      word_count_d = word_count_q;
      flush_done_c = 1'b0;

      if (m_valid_q && bus.m_ready) begin
         m_valid_d    = 1'b0;
         word_count_d = word_count_q + CNT_WIDTH'(1);
      end

      unique case (state_q)
         StFill: begin
            if (pop) begin
               if (idx_q == LastIdx) begin
                  m_data_d  = lane_word;
                  m_keep_d  = '1;
                  m_last_d  = 1'b0;
                  m_valid_d = 1'b1;
                  idx_d     = '0;
                  asm_d     = '0;
               end else begin
                  asm_d = lane_word;
                  idx_d = idx_q + IdxW'(1);
               end
            end
            if (flush) begin
               state_d = StFlush;
            end
         end
         StFlush: begin
            if (slot_free) begin
               flush_done_c = 1'b1;
               state_d      = StFill;
               if (idx_q != '0) begin
                  // Unfilled lanes are already zero since asm is cleared on every load.
                  m_data_d  = asm_q;
                  m_keep_d  = keep_partial;
                  m_last_d  = 1'b1;
                  m_valid_d = 1'b1;
                  idx_d     = '0;
                  asm_d     = '0;
               end
            end
         end
         default: state_d = StFill;
      endcase
   end

   always_ff @(posedge clk_read or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StFill;
         idx_q        <= '0;
         asm_q        <= '0;
         m_valid_q    <= 1'b0;
         m_data_q     <= '0;
         m_keep_q     <= '0;
         m_last_q     <= 1'b0;
         word_count_q <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         asm_q        <= asm_d;
         m_valid_q    <= m_valid_d;
         m_data_q     <= m_data_d;
         m_keep_q     <= m_keep_d;
         m_last_q     <= m_last_d;
         word_count_q <= word_count_d;
      end
   end

   assign bus.fifo_read = pop;
   assign bus.m_valid   = m_valid_q;
   assign bus.m_data    = m_data_q;
   assign bus.m_keep    = m_keep_q;
   assign bus.m_last    = m_last_q;
   assign flush_done    = flush_done_c;
   assign word_count    = word_count_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Scoreboard bench for fifo_rd_packer: a queue models the FWFT FIFO, expected
// words are queued with the stimulus and compared on each accepted beat.
module tb_fifo_rd_packer;

   localparam int unsigned DW = 8;
   localparam int unsigned RT = 4;
   localparam int unsigned CW = 16;

   logic          clk_read = 1'b0;
   logic          rst_n;
   logic          flush;
   logic          flush_done;
   logic [CW-1:0] word_count;
   logic          flush_w;
   logic          flush_done_w;
   logic [3:0]    word_count_w;

   always #5 clk_read = ~clk_read;

   fifo_rd_packer_if #(.DATA_WIDTH(DW), .RATIO(RT)) bus ();
   fifo_rd_packer_if #(.DATA_WIDTH(DW), .RATIO(RT)) bus_w ();

   fifo_rd_packer #(.DATA_WIDTH(DW), .RATIO(RT), .CNT_WIDTH(CW)) dut (
      .clk_read   (clk_read),
      .rst_n      (rst_n),
      .flush      (flush),
      .flush_done (flush_done),
      .word_count (word_count),
      .bus        (bus)
   );

   // Narrow counter instance so the wrap is reachable in a short run.
   fifo_rd_packer #(.DATA_WIDTH(DW), .RATIO(RT), .CNT_WIDTH(4)) dut_w (
      .clk_read   (clk_read),
      .rst_n      (rst_n),
      .flush      (flush_w),
      .flush_done (flush_done_w),
      .word_count (word_count_w),
      .bus        (bus_w)
   );

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
   } word_t;

   word_t      sb[$];
   logic [7:0] fifo_m[$];
   int         n_tests = 0;
   int         n_fail  = 0;
   int         pops    = 0;
   int         fd_cnt  = 0;
   int         acc_cnt = 0;
   int         w_acc   = 0;
   int         fd0, a0;
   logic       s_read, s_valid, s_fd;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic exp_word(input logic [31:0] d, input logic [3:0] k, input logic l);
      word_t w;
      w.data = d;
      w.keep = k;
      w.last = l;
      sb.push_back(w);
   endtask

   task automatic push(input logic [7:0] v);
      fifo_m.push_back(v);
   endtask

   // One clock: present FIFO head, sample mid-low-phase, advance to next negedge.
   task automatic tick();
      word_t e;
      bus.fifo_empty = (fifo_m.size() == 0);
      bus.fifo_data  = (fifo_m.size() != 0) ? fifo_m[0] : 8'h00;
      #2;
      s_read  = bus.fifo_read;
      s_valid = bus.m_valid;
      s_fd    = flush_done;
      if (s_fd) fd_cnt++;
      if (s_read) pops++;
      if (bus.m_valid && bus.m_ready) begin
         acc_cnt++;
         if (sb.size() == 0) begin
            check("sb_underflow", 64'(sb.size()), 64'd1);
         end else begin
            e = sb.pop_front();
            check("m_data", 64'(bus.m_data), 64'(e.data));
            check("m_keep", 64'(bus.m_keep), 64'(e.keep));
            check("m_last", 64'(bus.m_last), 64'(e.last));
         end
      end
      if (bus_w.m_valid && bus_w.m_ready) w_acc++;
      @(negedge clk_read);
      if (s_read) void'(fifo_m.pop_front());
   endtask

   task automatic drain(input int max);
      int   n;
      logic busy;
      n    = 0;
      busy = 1'b1;
      while (busy && n < max) begin
         tick();
         n++;
         busy = (sb.size() != 0) || (fifo_m.size() != 0) || bus.m_valid;
      end
      check("drain_timeout", 64'(busy), 64'd0);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n            = 1'b0;
      flush            = 1'b0;
      flush_w          = 1'b0;
      bus.m_ready      = 1'b0;
      bus.fifo_empty   = 1'b0;
      bus.fifo_data    = 8'h5A;
      bus_w.fifo_empty = 1'b1;
      bus_w.fifo_data  = 8'h00;
      bus_w.m_ready    = 1'b1;

      // Reset state with a non-empty FIFO
      repeat (2) @(negedge clk_read);
      #2;
      check("rst_fifo_read", 64'(bus.fifo_read), 64'd0);
      check("rst_m_valid", 64'(bus.m_valid), 64'd0);
      check("rst_m_data", 64'(bus.m_data), 64'd0);
      check("rst_m_keep", 64'(bus.m_keep), 64'd0);
      check("rst_m_last", 64'(bus.m_last), 64'd0);
      check("rst_flush_done", 64'(flush_done), 64'd0);
      check("rst_word_count", 64'(word_count), 64'd0);
      @(negedge clk_read);
      rst_n = 1'b1;

      // Single full word, one pop per cycle, valid the cycle after the last pop
      bus.m_ready = 1'b1;
      for (int i = 1; i <= 4; i++) push(8'(i));
      exp_word(32'h04030201, 4'hF, 1'b0);
      pops = 0;
      repeat (4) tick();
      check("t2_pops", 64'(pops), 64'd4);
      tick();
      check("t2_latency", 64'(s_valid), 64'd1);
      drain(20);
      check("t2_word_count", 64'(word_count), 64'd1);

      // Backpressure stalls the last lane; release gives back-to-back words
      bus.m_ready = 1'b0;
      for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
      exp_word(32'h13121110, 4'hF, 1'b0);
      exp_word(32'h17161514, 4'hF, 1'b0);
      pops = 0;
      repeat (10) tick();
      check("t3_pops_stalled", 64'(pops), 64'd7);
      check("t3_read_stalled", 64'(s_read), 64'd0);
      check("t3_hold_data", 64'(bus.m_data), 64'h13121110);
      bus.m_ready = 1'b1;
      tick();
      tick();
      check("t3_b2b_valid", 64'(s_valid), 64'd1);
      drain(20);
      check("t3_word_count", 64'(word_count), 64'd3);

      // Partial flush of two lanes; FIFO refilled during S_FLUSH must not pop
      exp_word(32'h0000BBAA, 4'h3, 1'b1);
      exp_word(32'hFFEEDDCC, 4'hF, 1'b0);
      fd0 = fd_cnt;
      push(8'hAA);
      push(8'hBB);
      tick();
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      push(8'hCC);
      tick();
      check("t4_read_in_flush", 64'(s_read), 64'd0);
      check("t4_flush_done", 64'(s_fd), 64'd1);
      push(8'hDD);
      push(8'hEE);
      push(8'hFF);
      drain(30);
      check("t4_fd_pulses", 64'(fd_cnt - fd0), 64'd1);
      check("t4_word_count", 64'(word_count), 64'd5);

      // Flush with nothing assembled: pulse only, no word
      fd0   = fd_cnt;
      a0    = acc_cnt;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      repeat (4) tick();
      check("t5_empty_fd_pulses", 64'(fd_cnt - fd0), 64'd1);
      check("t5_empty_no_word", 64'(acc_cnt - a0), 64'd0);

      // Flush coincident with the fourth pop: full word, then no extra word
      exp_word(32'h24232221, 4'hF, 1'b0);
      for (int i = 1; i <= 4; i++) push(8'(8'h20 + i));
      fd0 = fd_cnt;
      a0  = acc_cnt;
      repeat (3) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      drain(20);
      repeat (2) tick();
      check("t5_full_fd_pulses", 64'(fd_cnt - fd0), 64'd1);
      check("t5_full_words", 64'(acc_cnt - a0), 64'd1);
      check("t5_word_count", 64'(word_count), 64'd6);

      // Async reset mid-word discards the two assembled lanes
      push(8'h31);
      push(8'h32);
      tick();
      tick();
      flush = 1'b1;
      #2;
      rst_n = 1'b0;
      flush = 1'b0;
      for (int i = 1; i <= 4; i++) push(8'(8'h40 + i));
      bus.fifo_empty = 1'b0;
      bus.fifo_data  = fifo_m[0];
      #1;
      check("t6_read_in_reset", 64'(bus.fifo_read), 64'd0);
      check("t6_wc_reset", 64'(word_count), 64'd0);
      @(negedge clk_read);
      rst_n = 1'b1;
      exp_word(32'h44434241, 4'hF, 1'b0);
      fd0 = fd_cnt;
      drain(20);
      check("t6_word_count", 64'(word_count), 64'd1);
      check("t6_flush_discarded", 64'(fd_cnt - fd0), 64'd0);

      // Counter wrap on the 4-bit instance: 15 -> 0 on the 16th accepted word
      w_acc = 0;
      bus_w.fifo_empty = 1'b0;
      for (int i = 0; i < 200 && w_acc < 15; i++) tick();
      check("wrap_pre_count", 64'(w_acc), 64'd15);
      check("wrap_pre_value", 64'(word_count_w), 64'hF);
      for (int i = 0; i < 20 && w_acc < 16; i++) tick();
      check("wrap_post_count", 64'(w_acc), 64'd16);
      check("wrap_post_value", 64'(word_count_w), 64'h0);
      bus_w.fifo_empty = 1'b1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
